fifo_param: RTL and testbench
=============================

# fifo_param

Parametrised synchronous FIFO succeeding the fixed 16-bit FIFO behind `FIFO_if`. Width, depth and almost-flag margins are configurable, and an occupancy count output is added. An optional first-word-fall-through read mode is selectable at compile time. It sits between producer and consumer logic in one clock domain and keeps the existing flag set (full/almostfull/empty/almostempty/overflow/underflow/wr_ack), so TEST-side benches carry over.

## Interface
- `DATA_WIDTH`, 16, data bus width
- `DEPTH`, 8, number of entries; power of two, ≥ 4
- `AF_LEVEL`, 1, almostfull asserts when free entries ≤ AF_LEVEL (1..DEPTH-1)
- `AE_LEVEL`, 1, almostempty asserts when stored entries ≤ AE_LEVEL (1..DEPTH-1)
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `data_in`  in  DATA_WIDTH  write data
- `wr_en`  in  1  write request
- `rd_en`  in  1  read request
- `data_out`  out  DATA_WIDTH  read data
- `full`, `almostfull`, `empty`, `almostempty`  out  1 each  occupancy flags
- `overflow`, `underflow`, `wr_ack`  out  1 each  per-request status
- `count`  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Write accepted iff `wr_en && !full`: store at wr_ptr, wr_ptr+1.
- Read accepted iff `rd_en && !empty`: take entry at rd_ptr, rd_ptr+1.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH with no special case.
- `count` changes by +1 (write only), −1 (read only), or 0 (both or neither).
- Simultaneous requests when full: read accepted, write rejected (overflow). When empty: write accepted, read rejected (underflow). Otherwise both are accepted and count is unchanged.
- Flags are combinational from `count`:
  - full = (count==DEPTH)
  - empty = (count==0)
  - almostfull = (count>=DEPTH-AF_LEVEL) && !full
  - almostempty = (count<=AE_LEVEL) && !empty
- `wr_ack`, `overflow`, `underflow` are registered single-cycle pulses reporting the previous cycle's request:
  - wr_ack = write accepted
  - overflow = wr_en && full
  - underflow = rd_en && empty
- Reset: count 0, pointers 0, data_out 0, empty 1, all other flags 0, wr_ack/overflow/underflow 0. Memory contents are not cleared.
- Reset mid-operation discards all stored data. Requests in a reset cycle are ignored and produce no status pulse next cycle.

## Timing
- Write to visible occupancy: count/flags update on the edge that accepts the write.
- Standard mode: `data_out` is registered and updates one cycle after an accepted read. It holds its value when there is no accepted read.
- Status pulses appear the cycle after the request, and last exactly one cycle per request cycle.
- Continuous wr_en+rd_en at mid occupancy sustains one transfer per cycle each way.

## Configuration
- Macro `FIFO_FWFT_EN`.
- Defined: first-word-fall-through mode.
  - `data_out` is combinationally the head entry whenever !empty; it is 0 when empty.
  - `rd_en` acknowledges/pops the current head; zero read latency.
  - Write-then-read of an empty FIFO presents data the cycle after the write edge.
- Undefined: standard registered-output mode as in Timing.
- Flags, count and status pulses are identical in both modes.

## Structure
- Package `fifo_pkg`:
  - default parameter constants (`FIFO_DEF_WIDTH`=16, `FIFO_DEF_DEPTH`=8)
  - `fifo_status_t` packed struct {wr_ack, overflow, underflow}
- Sub-module `fifo_mem`: DEPTH×DATA_WIDTH register array with one synchronous write port and one asynchronous read port.
- `fifo_param` holds pointers, count, flag logic and the output register.
- Parameter legality is checked by elaboration-time assertions: DEPTH power of two, levels in range.

## Test plan
- Reset then idle → empty=1, count=0, all pulses 0, data_out=0.
- Write 8 values 0x0001..0x0008 (DEPTH=8) → wr_ack each cycle; almostfull at count=7; full at count=8. A 9th write → overflow=1, wr_ack=0, count stays 8.
- Read 8 from full → data 0x0001..0x0008 in order, 1-cycle latency (0 with FWFT). A further read → underflow=1; empty=1.
- Fill 5, then wr_en+rd_en for 20 cycles with incrementing data → count fixed at 5, ordered data across pointer wrap.
- Full + simultaneous wr_en/rd_en → read succeeds, overflow=1, count 8→7. Empty + both → wr_ack=1, underflow=1, count 0→1.
- Fill 4, assert rst for one cycle with wr_en=1 → count=0, empty=1, no wr_ack next cycle. A subsequent read → underflow.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared definitions for the parametrised synchronous FIFO.
//                Holds the default geometry constants and the packed
//                per-request status record {wr_ack, overflow, underflow}.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int FIFO_DEF_WIDTH = 16;
    localparam int FIFO_DEF_DEPTH = 8;

    typedef struct packed {
        logic wr_ack;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_mem
//  Description : DEPTH x DATA_WIDTH register array, one synchronous write
//                port and one asynchronous read port. Contents are never
//                reset.
//  Ports       : clk        - clock, rising edge
//                i_wr_en    - write strobe
//                i_wr_addr  - write address
//                i_wr_data  - write data
//                i_rd_addr  - read address
//                o_rd_data  - read data (combinational from i_rd_addr)
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // DEPTH is a power of two, so every address is a valid index.
    assign o_rd_data = r_mem[i_rd_addr];

endmodule : fifo_mem
`default_nettype wire

// File: rtl/fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_param
//  Description : Parametrised single-clock FIFO with occupancy count,
//                full/almostfull/empty/almostempty flags and registered
//                wr_ack/overflow/underflow pulses.
//                Compile-time option: define FIFO_FWFT_EN for
//                first-word-fall-through reads (head entry shown
//                combinationally, rd_en pops it). Otherwise data_out is
//                registered and updates one cycle after an accepted read.
//  Ports       : clk, rst (synchronous, active high)
//                data_in, wr_en, rd_en  - producer / consumer requests
//                data_out               - read data
//                full, almostfull, empty, almostempty - occupancy flags
//                overflow, underflow, wr_ack          - status pulses
//                count                  - current occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DEF_WIDTH,
    parameter int DEPTH      = FIFO_DEF_DEPTH,
    parameter int AF_LEVEL   = 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    wr_en,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    full,
    output logic                    almostfull,
    output logic                    empty,
    output logic                    almostempty,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    wr_ack,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_af_thr  = c_cnt_w'(DEPTH - AF_LEVEL);
    localparam logic [c_cnt_w-1:0] c_ae_thr  = c_cnt_w'(AE_LEVEL);

    // ------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("fifo_param: DEPTH must be a power of two and >= 4");
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH - 1)) begin : g_chk_af
        $error("fifo_param: AF_LEVEL must be in 1..DEPTH-1");
    end
    if ((AE_LEVEL < 1) || (AE_LEVEL > DEPTH - 1)) begin : g_chk_ae
        $error("fifo_param: AE_LEVEL must be in 1..DEPTH-1");
    end

    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;
    fifo_status_t          r_status;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    assign w_full  = (r_count == c_full);
    assign w_empty = (r_count == '0);

    // A request during reset must not touch the array either, so the
    // write strobe is qualified with rst as well as with full.
    assign w_wr_acc = wr_en && !w_full && !rst;
    assign w_rd_acc = rd_en && !w_empty && !rst;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (c_ptr_w)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_in),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    // ------------------------------------------------------------------
    // Pointers and occupancy; pointers wrap naturally modulo DEPTH
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status pulses report the previous cycle's request
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_status <= '0;
        end else begin
            r_status.wr_ack    <= w_wr_acc;
            r_status.overflow  <= wr_en && w_full;
            r_status.underflow <= rd_en && w_empty;
        end
    end

    // ------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------
`ifdef FIFO_FWFT_EN
    // Head entry is visible as soon as it is stored; forced to zero when
    // empty so stale array contents never leak out.
    assign data_out = w_empty ? '0 : w_rd_data;
`else
    logic [DATA_WIDTH-1:0] r_data_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
        end else if (w_rd_acc) begin
            r_data_out <= w_rd_data;
        end
    end

    assign data_out = r_data_out;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign count       = r_count;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almostfull  = (r_count >= c_af_thr) && !w_full;
    assign almostempty = (r_count <= c_ae_thr) && !w_empty;
    assign wr_ack      = r_status.wr_ack;
    assign overflow    = r_status.overflow;
    assign underflow   = r_status.underflow;

endmodule : fifo_param
`default_nettype wire

// File: tb/tb_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_param
//  Description : Self-checking bench for fifo_param (DEPTH=8, AF=AE=1).
//                A driver issues directed requests on the falling edge and
//                pushes the expected post-edge state onto a queue; a
//                monitor pops and compares after every rising edge.
//                Works in both standard and FIFO_FWFT_EN builds.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_param;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int AF    = 1;
    localparam int AE    = 1;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          wr_en   = 1'b0;
    logic          rd_en   = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          full, almostfull, empty, almostempty;
    logic          overflow, underflow, wr_ack;
    logic [CW-1:0] count;

    fifo_param #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .full        (full),
        .almostfull  (almostfull),
        .empty       (empty),
        .almostempty (almostempty),
        .overflow    (overflow),
        .underflow   (underflow),
        .wr_ack      (wr_ack),
        .count       (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        logic [DW-1:0] dout;
        int            cnt;
        logic          full;
        logic          af;
        logic          empty;
        logic          ae;
        logic          ack;
        logic          ov;
        logic          un;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_dout = '0;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input string name,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=0x%0h expected=0x%0h", tag, name, act, req);
        end
    endtask

    // One request cycle: drive inputs, advance the reference model and
    // record what the DUT must show after the coming rising edge.
    task automatic step(input logic r, input logic w, input logic rd,
                        input logic [DW-1:0] d, input string tag);
        exp_t          e;
        logic [DW-1:0] v;
        bit            mfull, mempty;
        @(negedge clk);
        rst = r; wr_en = w; rd_en = rd; data_in = d;
        if (r) begin
            m_q.delete();
            m_dout = '0;
            e.ack = 1'b0; e.ov = 1'b0; e.un = 1'b0;
        end else begin
            mfull  = (m_q.size() == DEPTH);
            mempty = (m_q.size() == 0);
            e.ack  = w && !mfull;
            e.ov   = w && mfull;
            e.un   = rd && mempty;
            if (rd && !mempty) begin
                v = m_q.pop_front();
                m_dout = v;
            end
            if (w && !mfull) m_q.push_back(d);
        end
        e.tag   = tag;
        e.cnt   = m_q.size();
        e.full  = (e.cnt == DEPTH);
        e.empty = (e.cnt == 0);
        e.af    = (e.cnt >= DEPTH - AF) && !e.full;
        e.ae    = (e.cnt <= AE) && !e.empty;
`ifdef FIFO_FWFT_EN
        e.dout  = (e.cnt == 0) ? '0 : m_q[0];
`else
        e.dout  = m_dout;
`endif
        exp_q.push_back(e);
    endtask

    // Monitor: compares the DUT state after each rising edge.
    initial begin : mon
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk(e.tag, "count",       32'(count),       32'(e.cnt));
                chk(e.tag, "data_out",    32'(data_out),    32'(e.dout));
                chk(e.tag, "full",        32'(full),        32'(e.full));
                chk(e.tag, "almostfull",  32'(almostfull),  32'(e.af));
                chk(e.tag, "empty",       32'(empty),       32'(e.empty));
                chk(e.tag, "almostempty", 32'(almostempty), 32'(e.ae));
                chk(e.tag, "wr_ack",      32'(wr_ack),      32'(e.ack));
                chk(e.tag, "overflow",    32'(overflow),    32'(e.ov));
                chk(e.tag, "underflow",   32'(underflow),   32'(e.un));
            end
        end
    end

    initial begin : drv
        // Reset then idle
        step(1'b1, 1'b0, 1'b0, '0, "reset");
        step(1'b1, 1'b0, 1'b0, '0, "reset");
        step(1'b0, 1'b0, 1'b0, '0, "idle");
        step(1'b0, 1'b0, 1'b0, '0, "idle");

        // Fill 0x0001..0x0008, then one write too many
        for (int i = 1; i <= DEPTH; i++) step(1'b0, 1'b1, 1'b0, DW'(i), "fill");
        step(1'b0, 1'b1, 1'b0, 16'h0009, "overflow");

        // Drain in order, then one read too many
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, '0, "drain");
        step(1'b0, 1'b0, 1'b1, '0, "underflow");

        // Fill 5, then sustained read+write across pointer wrap
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, DW'(16'h0100 + i), "fill5");
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, DW'(16'h0200 + i), "stream");

        // Top up to full, then simultaneous request while full
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, DW'(16'h0300 + i), "topup");
        step(1'b0, 1'b1, 1'b1, 16'h0AAA, "both_full");

        // Drain the remaining 7, then simultaneous request while empty
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b0, 1'b1, '0, "drain2");
        step(1'b0, 1'b1, 1'b1, 16'h0BBB, "both_empty");

        // Bring to 4 entries, reset mid-operation with wr_en high
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, DW'(16'h0400 + i), "fill4");
        step(1'b1, 1'b1, 1'b0, 16'h0055, "mid_reset");
        step(1'b0, 1'b0, 1'b0, '0, "post_reset");
        step(1'b0, 1'b0, 1'b1, '0, "post_reset_rd");

        // Fresh write/read after reset proves the discarded data is gone
        step(1'b0, 1'b1, 1'b0, 16'h0C0D, "refill");
        step(1'b0, 1'b0, 1'b1, '0, "reread");
        step(1'b0, 1'b0, 1'b0, '0, "idle_end");

        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue actual=%0d expected=0 pending entries", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fifo_param
`default_nettype wire
